// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator-machine controller: opcodes, ALU and ACC-mux codes,
// FSM state codes and the opcode classifier used at decode.
package acc_ctrl_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_XOR   = 8'h05;
  localparam logic [7:0] OP_JUMP  = 8'h06;
  localparam logic [7:0] OP_JUMPZ = 8'h07;
  localparam logic [7:0] OP_STORE = 8'h08;
  localparam logic [7:0] OP_LOAD  = 8'h09;
  localparam logic [7:0] OP_HALT  = 8'h0A;

  localparam logic [1:0] ALU_XOR = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd3;

  localparam logic [1:0] ACC_SRC_MDR = 2'd0;
  localparam logic [1:0] ACC_SRC_ALU = 2'd1;
  localparam logic [1:0] ACC_SRC_EXU = 2'd2;

  localparam logic [4:0] S_FETCH0 = 5'd0;
  localparam logic [4:0] S_FETCH1 = 5'd1;
  localparam logic [4:0] S_FETCH2 = 5'd2;
  localparam logic [4:0] S_DECODE = 5'd3;
  localparam logic [4:0] S_RD     = 5'd4;
  localparam logic [4:0] S_ALU_WB = 5'd5;
  localparam logic [4:0] S_LD_WB  = 5'd6;
  localparam logic [4:0] S_ST     = 5'd7;
  localparam logic [4:0] S_JMP    = 5'd8;
  localparam logic [4:0] S_EXU_GO = 5'd9;
  localparam logic [4:0] S_EXU_WT = 5'd10;
  localparam logic [4:0] S_EXU_WB = 5'd11;
  localparam logic [4:0] S_HALT   = 5'd12;

  typedef enum logic [3:0] {
    OPC_NOP,
    OPC_ADD,
    OPC_SUB,
    OPC_MUL,
    OPC_DIV,
    OPC_XOR,
    OPC_JUMP,
    OPC_JUMPZ,
    OPC_STORE,
    OPC_LOAD,
    OPC_HALT,
    OPC_ILL
  } op_e;

  function automatic op_e classify_op(input logic [7:0] op);
    op_e c;
    case (op)
      OP_NOP:   c = OPC_NOP;
      OP_ADD:   c = OPC_ADD;
      OP_SUB:   c = OPC_SUB;
      OP_MUL:   c = OPC_MUL;
      OP_DIV:   c = OPC_DIV;
      OP_XOR:   c = OPC_XOR;
      OP_JUMP:  c = OPC_JUMP;
      OP_JUMPZ: c = OPC_JUMPZ;
      OP_STORE: c = OPC_STORE;
      OP_LOAD:  c = OPC_LOAD;
      OP_HALT:  c = OPC_HALT;
      default:  c = OPC_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_ctrl_if.sv
// Controller <-> datapath/memory/EXU bundle. The controller sits on the master side,
// the datapath (register file, memory port, MUL/DIV unit) on the slave side.
interface acc_ctrl_if #(
  parameter int OPCODE_W = 8,
  parameter int DATA_W   = 16
) ();

  logic [OPCODE_W-1:0] opcode;
  logic                zflag;
  logic [DATA_W-1:0]   ACC_reg;
  logic [DATA_W-1:0]   MDR_reg;
  logic                memReady;
  logic                exuDone;

  logic       muxPC;
  logic       muxMAR;
  logic [1:0] muxACC;
  logic       loadPC;
  logic       loadMAR;
  logic       loadMDR;
  logic       loadIR;
  logic       loadACC;
  logic       MemRW;
  logic       memReq;
  logic [1:0] opALU;
  logic       exuStart;
  logic       exuSel;
  logic       halted;
  logic       illegalOp;
  logic       divByZero;
  logic       exuTimeout;

  modport master (
    input  opcode, zflag, ACC_reg, MDR_reg, memReady, exuDone,
    output muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC,
           MemRW, memReq, opALU, exuStart, exuSel, halted,
           illegalOp, divByZero, exuTimeout
  );

  modport slave (
    output opcode, zflag, ACC_reg, MDR_reg, memReady, exuDone,
    input  muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC,
           MemRW, memReq, opALU, exuStart, exuSel, halted,
           illegalOp, divByZero, exuTimeout
  );

endinterface

// File: rtl/acc_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller for the accumulator datapath, with memory
// wait states, a MUL/DIV start/done handshake, EXU timeout, /0 and illegal-opcode traps.
module acc_ctrl_fsm
  import acc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int DATA_W      = 16,
  parameter int EXU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  acc_ctrl_if.master bus
);

  localparam int               CNT_W    = $clog2(EXU_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXU_TIMEOUT - 1);

  logic [4:0]       state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             divz_q, divz_d;
  logic             tmo_q, tmo_d;

  logic [7:0] op8;
  logic       op_hi_nz;
  op_e        dec_op;
  logic       is_div;
  logic       div_zero;
  logic       jmp_take;

  // Opcodes wider than 8 bits are illegal whenever any upper bit is set.
  if (OPCODE_W > 8) begin : g_op_wide
    assign op8      = bus.opcode[7:0];
    assign op_hi_nz = |bus.opcode[OPCODE_W-1:8];
  end else begin : g_op_narrow
    assign op8      = 8'(bus.opcode);
    assign op_hi_nz = 1'b0;
  end

  assign dec_op   = op_hi_nz ? OPC_ILL : classify_op(op8);
  assign is_div   = (op_q == OPC_DIV);
  assign div_zero = is_div && (bus.MDR_reg == {DATA_W{1'b0}});
  assign jmp_take = (op_q == OPC_JUMP) || ((op_q == OPC_JUMPZ) && bus.zflag);

  // ACC_reg is an EXU operand routed by the datapath; the controller never inspects it.
  logic unused_acc;
  assign unused_acc = ^bus.ACC_reg;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    divz_d    = divz_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: if (bus.memReady) state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        op_d = dec_op;
        case (dec_op)
          OPC_NOP:   state_d = S_FETCH0;
          OPC_HALT:  state_d = S_HALT;
          OPC_ADD, OPC_SUB, OPC_XOR, OPC_LOAD, OPC_MUL, OPC_DIV:
                     state_d = S_RD;
          OPC_STORE: state_d = S_ST;
          OPC_JUMP, OPC_JUMPZ:
                     state_d = S_JMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_RD: begin
        if (bus.memReady) begin
          case (op_q)
            OPC_MUL, OPC_DIV: state_d = S_EXU_GO;
            OPC_LOAD:         state_d = S_LD_WB;
            default:          state_d = S_ALU_WB;
          endcase
        end
      end
      S_ALU_WB, S_LD_WB, S_JMP, S_EXU_WB: state_d = S_FETCH0;
      S_ST: if (bus.memReady) state_d = S_FETCH0;
      S_EXU_GO: begin
        cnt_d = '0;
        if (div_zero) begin
          divz_d  = 1'b1;
          state_d = S_FETCH0;
        end else begin
          state_d = S_EXU_WT;
        end
      end
      // A done pulse on the final allowed cycle takes priority over the timeout trap.
      S_EXU_WT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.exuDone) begin
          state_d = S_EXU_WB;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH0;
      op_q      <= OPC_NOP;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      divz_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      divz_q    <= divz_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    bus.muxPC    = 1'b0;
    bus.muxMAR   = 1'b0;
    bus.muxACC   = ACC_SRC_MDR;
    bus.loadPC   = 1'b0;
    bus.loadMAR  = 1'b0;
    bus.loadMDR  = 1'b0;
    bus.loadIR   = 1'b0;
    bus.loadACC  = 1'b0;
    bus.MemRW    = 1'b0;
    bus.memReq   = 1'b0;
    bus.opALU    = ALU_XOR;
    bus.exuStart = 1'b0;
    bus.exuSel   = 1'b0;
    bus.halted   = 1'b0;
    case (state_q)
      S_FETCH0: begin
        bus.loadMAR = 1'b1;
        bus.loadPC  = 1'b1;
      end
      S_FETCH1, S_RD: begin
        bus.memReq  = 1'b1;
        bus.loadMDR = bus.memReady;
      end
      S_FETCH2: bus.loadIR = 1'b1;
      S_DECODE: begin
        bus.muxMAR  = 1'b1;
        bus.loadMAR = 1'b1;
      end
      S_ALU_WB: begin
        bus.loadACC = 1'b1;
        bus.muxACC  = ACC_SRC_ALU;
        case (op_q)
          OPC_ADD: bus.opALU = ALU_ADD;
          OPC_SUB: bus.opALU = ALU_SUB;
          default: bus.opALU = ALU_XOR;
        endcase
      end
      S_LD_WB: begin
        bus.loadACC = 1'b1;
        bus.muxACC  = ACC_SRC_MDR;
      end
      S_ST: begin
        bus.memReq = 1'b1;
        bus.MemRW  = 1'b1;
      end
      S_JMP: begin
        bus.muxPC  = 1'b1;
        bus.loadPC = jmp_take;
      end
      S_EXU_GO: begin
        bus.exuStart = !div_zero;
        bus.exuSel   = is_div;
      end
      S_EXU_WT: bus.exuSel = is_div;
      S_EXU_WB: begin
        bus.loadACC = 1'b1;
        bus.muxACC  = ACC_SRC_EXU;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.illegalOp  = illegal_q;
  assign bus.divByZero  = divz_q;
  assign bus.exuTimeout = tmo_q;

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: each step queues the per-cycle inputs and the expected
// output vector, then the queue is drained one clock per entry and compared at negedge.
module tb_acc_ctrl_fsm;

  localparam int OPCODE_W    = 8;
  localparam int DATA_W      = 16;
  localparam int EXU_TIMEOUT = 64;

  logic clk;
  logic rst;

  acc_ctrl_if #(.OPCODE_W(OPCODE_W), .DATA_W(DATA_W)) bus ();

  acc_ctrl_fsm #(
    .OPCODE_W   (OPCODE_W),
    .DATA_W     (DATA_W),
    .EXU_TIMEOUT(EXU_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       mpc;
    logic       mmar;
    logic [1:0] macc;
    logic       lpc;
    logic       lmar;
    logic       lmdr;
    logic       lir;
    logic       lacc;
    logic       rw;
    logic       req;
    logic [1:0] alu;
    logic       st;
    logic       sel;
    logic       hlt;
  } ctl_t;

  logic [19:0] exp_q[$];
  logic        mr_q[$];
  logic        dn_q[$];
  string       tag_q[$];

  logic  exp_ill, exp_dbz, exp_to;
  string cur;
  int    ntests = 0;
  int    nfail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] obs();
    return {bus.muxPC, bus.muxMAR, bus.muxACC, bus.loadPC, bus.loadMAR, bus.loadMDR,
            bus.loadIR, bus.loadACC, bus.MemRW, bus.memReq, bus.opALU, bus.exuStart,
            bus.exuSel, bus.halted, bus.illegalOp, bus.divByZero, bus.exuTimeout};
  endfunction

  task automatic push(input string t, input logic mr, input logic dn, input ctl_t c);
    exp_q.push_back({c, exp_ill, exp_dbz, exp_to});
    mr_q.push_back(mr);
    dn_q.push_back(dn);
    tag_q.push_back({cur, ".", t});
  endtask

  task automatic e_f0();
    ctl_t c;
    c = '0; c.lpc = 1'b1; c.lmar = 1'b1;
    push("fetch0", 1'b1, 1'b0, c);
  endtask

  task automatic e_f1(input logic mr);
    ctl_t c;
    c = '0; c.req = 1'b1; c.lmdr = mr;
    push("fetch1", mr, 1'b0, c);
  endtask

  task automatic e_f2();
    ctl_t c;
    c = '0; c.lir = 1'b1;
    push("fetch2", 1'b1, 1'b0, c);
  endtask

  task automatic e_dec();
    ctl_t c;
    c = '0; c.mmar = 1'b1; c.lmar = 1'b1;
    push("decode", 1'b1, 1'b0, c);
  endtask

  task automatic e_fetch();
    e_f0(); e_f1(1'b1); e_f2(); e_dec();
  endtask

  task automatic e_rd(input logic mr, input logic dn);
    ctl_t c;
    c = '0; c.req = 1'b1; c.lmdr = mr;
    push("rd", mr, dn, c);
  endtask

  task automatic e_aluwb(input logic [1:0] a);
    ctl_t c;
    c = '0; c.lacc = 1'b1; c.macc = 2'd1; c.alu = a;
    push("alu_wb", 1'b1, 1'b0, c);
  endtask

  task automatic e_ldwb();
    ctl_t c;
    c = '0; c.lacc = 1'b1; c.macc = 2'd0;
    push("ld_wb", 1'b1, 1'b0, c);
  endtask

  task automatic e_st(input logic mr);
    ctl_t c;
    c = '0; c.req = 1'b1; c.rw = 1'b1;
    push("st", mr, 1'b0, c);
  endtask

  task automatic e_jmp(input logic take);
    ctl_t c;
    c = '0; c.mpc = 1'b1; c.lpc = take;
    push("jmp", 1'b1, 1'b0, c);
  endtask

  task automatic e_go(input logic st, input logic sel);
    ctl_t c;
    c = '0; c.st = st; c.sel = sel;
    push("exu_go", 1'b1, 1'b0, c);
  endtask

  task automatic e_wt(input logic sel, input logic dn);
    ctl_t c;
    c = '0; c.sel = sel;
    push("exu_wt", 1'b1, dn, c);
  endtask

  task automatic e_exwb();
    ctl_t c;
    c = '0; c.lacc = 1'b1; c.macc = 2'd2;
    push("exu_wb", 1'b1, 1'b0, c);
  endtask

  task automatic e_halt();
    ctl_t c;
    c = '0; c.hlt = 1'b1;
    push("halt", 1'b1, 1'b0, c);
  endtask

  task automatic start(input string name, input logic [7:0] op, input logic z,
                       input logic [15:0] mdr, input logic [15:0] acc);
    cur          = name;
    bus.opcode   = op;
    bus.zflag    = z;
    bus.MDR_reg  = mdr;
    bus.ACC_reg  = acc;
  endtask

  // Entered and left at posedge+1; one queue entry per clock.
  task automatic run_q();
    logic [19:0] e, o;
    string       t;
    while (exp_q.size() > 0) begin
      bus.memReady = mr_q.pop_front();
      bus.exuDone  = dn_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = obs();
      ntests++;
      assert (o === e) else begin
        nfail++;
        $error("FAIL %s: observed %05h expected %05h", t, o, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_flags();
    exp_ill = 1'b0; exp_dbz = 1'b0; exp_to = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.opcode = '0; bus.zflag = 1'b0; bus.ACC_reg = '0; bus.MDR_reg = '0;
    bus.memReady = 1'b0; bus.exuDone = 1'b0;
    clear_flags();
    repeat (2) @(posedge clk);
    #1;

    cur = "reset"; e_f0(); run_q();
    rst = 1'b1;

    start("nop", 8'h00, 1'b0, 16'd0, 16'd0);
    e_fetch(); run_q();

    start("add", 8'h01, 1'b0, 16'd3, 16'd5);
    e_fetch(); e_rd(1'b1, 1'b0); e_aluwb(2'd1); run_q();

    start("sub", 8'h02, 1'b0, 16'd3, 16'd5);
    e_fetch(); e_rd(1'b1, 1'b0); e_aluwb(2'd3); run_q();

    start("xor", 8'h05, 1'b0, 16'h00F0, 16'h0F0F);
    e_fetch(); e_rd(1'b1, 1'b0); e_aluwb(2'd0); run_q();

    start("load_wait", 8'h09, 1'b0, 16'd9, 16'd0);
    e_fetch();
    for (int i = 0; i < 3; i++) e_rd(1'b0, 1'b0);
    e_rd(1'b1, 1'b0); e_ldwb(); run_q();

    start("store_wait", 8'h08, 1'b0, 16'd0, 16'd7);
    e_f0(); e_f1(1'b0); e_f1(1'b0); e_f1(1'b1); e_f2(); e_dec();
    e_st(1'b0); e_st(1'b1); run_q();

    start("jump", 8'h06, 1'b0, 16'd0, 16'd0);
    e_fetch(); e_jmp(1'b1); run_q();

    start("jumpz_taken", 8'h07, 1'b1, 16'd0, 16'd0);
    e_fetch(); e_jmp(1'b1); run_q();

    start("jumpz_not", 8'h07, 1'b0, 16'd0, 16'd4);
    e_fetch(); e_jmp(1'b0); run_q();

    start("div0", 8'h04, 1'b0, 16'd0, 16'd12);
    e_fetch(); e_rd(1'b1, 1'b0); e_go(1'b0, 1'b1); run_q();
    exp_dbz = 1'b1;

    start("mul10", 8'h03, 1'b0, 16'd4, 16'd6);
    e_fetch(); e_rd(1'b1, 1'b0); e_go(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) e_wt(1'b0, 1'b0);
    e_wt(1'b0, 1'b1); e_exwb(); run_q();

    start("div7", 8'h04, 1'b0, 16'd7, 16'd21);
    e_fetch(); e_rd(1'b1, 1'b1); e_go(1'b1, 1'b1);
    e_wt(1'b1, 1'b0); e_wt(1'b1, 1'b0); e_wt(1'b1, 1'b1); e_exwb(); run_q();

    start("done_on_last", 8'h03, 1'b0, 16'd2, 16'd2);
    e_fetch(); e_rd(1'b1, 1'b0); e_go(1'b1, 1'b0);
    for (int i = 0; i < EXU_TIMEOUT - 1; i++) e_wt(1'b0, 1'b0);
    e_wt(1'b0, 1'b1); e_exwb(); run_q();

    start("rst_in_wt", 8'h03, 1'b0, 16'd2, 16'd2);
    e_fetch(); e_rd(1'b1, 1'b0); e_go(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) e_wt(1'b0, 1'b0);
    run_q();
    rst = 1'b0; e_wt(1'b0, 1'b0); run_q();
    rst = 1'b1; clear_flags();

    start("post_rst", 8'h00, 1'b0, 16'd0, 16'd0);
    e_f0(); e_f1(1'b1); e_f2(); e_dec(); run_q();

    start("illegal", 8'hFF, 1'b0, 16'd0, 16'd0);
    e_fetch(); run_q();
    exp_ill = 1'b1;
    e_halt(); e_halt(); run_q();
    rst = 1'b0; e_halt(); run_q();
    rst = 1'b1; clear_flags();

    start("halt_op", 8'h0A, 1'b0, 16'd0, 16'd0);
    e_fetch(); e_halt(); e_halt(); run_q();
    rst = 1'b0; e_halt(); run_q();
    rst = 1'b1; clear_flags();

    start("mul_timeout", 8'h03, 1'b0, 16'd3, 16'd3);
    e_fetch(); e_rd(1'b1, 1'b0); e_go(1'b1, 1'b0);
    for (int i = 0; i < EXU_TIMEOUT; i++) e_wt(1'b0, 1'b0);
    run_q();
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++) e_halt();
    run_q();
    rst = 1'b0; e_halt(); run_q();
    rst = 1'b1; clear_flags();

    start("after_timeout", 8'h00, 1'b0, 16'd0, 16'd0);
    e_fetch(); run_q();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
